async_receiver_core: RTL and testbench

//  8N1 UART receiver; the receive end of the async_transmitter serial link.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 35 +++
 rtl/async_receiver_core.sv | 171 +++++++++++++++++
 tb/tb_async_receiver_core.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the async serial link: receiver FSM states, frame width,
// default oversampling rate and the 3-sample majority vote.
package uart_pkg;

  localparam int unsigned DATA_BITS          = 8;
  localparam int unsigned DEFAULT_OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clock pulse every DIV clocks, held in phase 0 while clr is high.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tick = ~clr & (cnt_q == CntLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/async_receiver_core.sv
// 8N1 UART receiver: 2-FF synchroniser, oversampled majority-vote bit recovery,
// early stop-bit acceptance and a one-deep valid/ready output register.
module async_receiver_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned SmpRate = BAUD * OVERSAMPLE;
  localparam int unsigned DIV     = (CLK_HZ + SmpRate / 2) / SmpRate;
  localparam int unsigned M       = OVERSAMPLE / 2;
  localparam int unsigned CntW    = $clog2(OVERSAMPLE);
  localparam int unsigned BitW    = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] SmpLo   = CntW'(M - 1);
  localparam logic [CntW-1:0] SmpMid  = CntW'(M);
  localparam logic [CntW-1:0] SmpHi   = CntW'(M + 1);
  localparam logic [CntW-1:0] SmpLast = CntW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  if (DIV < 1) begin : gen_div_err
    $error("async_receiver_core: clock too slow for BAUD*OVERSAMPLE (DIV < 1)");
  end
  if ((OVERSAMPLE < 8) || (OVERSAMPLE % 2 != 0)) begin : gen_os_err
    $error("async_receiver_core: OVERSAMPLE must be even and >= 8");
  end

  logic                 sync1_q, sync2_q, rxd_s;
  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      smp_cnt_q, smp_cnt_d;
  logic [BitW-1:0]      bit_idx_q, bit_idx_d;
  logic [1:0]           smp_q, smp_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick, vote, stop_good;

  assign rxd_s = sync2_q;

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == StIdle),
    .tick  (tick)
  );

  // smp_q holds samples M-1 and M; the live line is the third vote at M+1.
  assign vote = majority3(smp_q[0], smp_q[1], rxd_s);

  always_comb begin
    state_d     = state_q;
    smp_cnt_d   = smp_cnt_q;
    bit_idx_d   = bit_idx_q;
    smp_d       = smp_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    stop_good   = 1'b0;

    if (tick && (state_q != StIdle) && (state_q != StBreak)) begin
      if (smp_cnt_q == SmpLo)  smp_d[0] = rxd_s;
      if (smp_cnt_q == SmpMid) smp_d[1] = rxd_s;
      smp_cnt_d = (smp_cnt_q == SmpLast) ? '0 : smp_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        smp_cnt_d = '0;
        if (!rxd_s) state_d = StStart;
      end
      StStart: begin
        if (tick) begin
          if ((smp_cnt_q == SmpHi) && vote) begin
            state_d = StIdle;
          end else if (smp_cnt_q == SmpLast) begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (smp_cnt_q == SmpHi) shift_d = {vote, shift_q[DATA_BITS-1:1]};
          if (smp_cnt_q == SmpLast) begin
            if (bit_idx_q == BitLast) state_d = StStop;
            else                      bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        // Decide at the vote instead of waiting out the bit, tolerating a fast transmitter.
        if (tick && (smp_cnt_q == SmpHi)) begin
          if (vote) begin
            stop_good = 1'b1;
            state_d   = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        if (rxd_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (stop_good) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= StIdle;
      smp_cnt_q   <= '0;
      bit_idx_q   <= '0;
      smp_q       <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync1_q     <= rxd;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      smp_cnt_q   <= smp_cnt_d;
      bit_idx_q   <= bit_idx_d;
      smp_q       <= smp_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_async_receiver_core.sv
// Bench for async_receiver_core at 16 clocks per bit: directed scenarios plus randomised frames
// checked against a one-deep-buffer model of the byte stream.
module tb_async_receiver_core;

  localparam int unsigned Bit = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;

  async_receiver_core #(
    .CLK_HZ     (1_600_000),
    .BAUD       (100_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: only accumulates; the test tasks compare deltas against their own expectations.
  logic [7:0] got[$];
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, valid_cycles = 0, busy_cycles = 0, stab_err = 0;
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
    end else begin
      if (rx_valid && rx_ready) got.push_back(rx_data);
      if (rx_valid) valid_cycles++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (frame_err && overrun) both_cnt++;
      if (busy) busy_cycles++;
      if (pv && !pr && (!rx_valid || rx_data !== pd)) stab_err++;
      pv = rx_valid;
      pr = rx_ready;
      pd = rx_data;
    end
  end

  // All stimulus changes happen 2 time units after a rising edge.
  task automatic line(input logic v, input int clks);
    rxd = v;
    repeat (clks) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    line(1'b0, Bit);
    for (int i = 0; i < 8; i++) line(b[i], Bit);
    line(stop, Bit);
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b0;
    #1;
    n_checks++;
    if ({rx_valid, frame_err, overrun, busy, rx_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 000",
               {rx_valid, frame_err, overrun, busy, rx_data});
    end
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    line(1'b1, 10);
    n_checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b valid=%b expected 0 0", busy, rx_valid);
    end
  endtask

  task automatic test_basic();
    int g0 = got.size(), f0 = fe_cnt, o0 = ov_cnt, v0 = valid_cycles;
    rx_ready = 1'b1;
    send_frame(8'hA5, 1'b1);
    line(1'b1, 2 * Bit);
    n_checks++;
    if (got.size() != g0 + 1 || got[got.size()-1] !== 8'hA5) begin
      n_fail++;
      $display("FAIL basic_data: got %0d bytes last=%h expected 1 byte a5", got.size() - g0,
               (got.size() > 0) ? got[got.size()-1] : 8'h00);
    end
    n_checks++;
    if (valid_cycles - v0 != 1) begin
      n_fail++;
      $display("FAIL basic_valid_width: got %0d clks expected 1", valid_cycles - v0);
    end
    n_checks++;
    if (fe_cnt != f0 || ov_cnt != o0) begin
      n_fail++;
      $display("FAIL basic_flags: fe=%0d ov=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic test_glitch_start();
    int b0 = busy_cycles, v0 = valid_cycles, f0 = fe_cnt, o0 = ov_cnt;
    line(1'b0, 4);
    line(1'b1, 14);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL glitch_idle: busy=%b expected 0", busy);
    end
    n_checks++;
    if (busy_cycles - b0 < 1 || busy_cycles - b0 > 12) begin
      n_fail++;
      $display("FAIL glitch_busy_len: got %0d clks expected 1..12", busy_cycles - b0);
    end
    line(1'b1, 12 * Bit);
    n_checks++;
    if (valid_cycles != v0 || fe_cnt != f0 || ov_cnt != o0) begin
      n_fail++;
      $display("FAIL glitch_flags: valid=%0d fe=%0d ov=%0d expected 0 0 0",
               valid_cycles - v0, fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic test_break();
    int f0 = fe_cnt, v0 = valid_cycles, g0 = got.size();
    rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0);
    line(1'b0, 40 * Bit);
    line(1'b1, 2 * Bit);
    n_checks++;
    if (fe_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL break_frame_err: got %0d pulses expected 1", fe_cnt - f0);
    end
    n_checks++;
    if (valid_cycles != v0) begin
      n_fail++;
      $display("FAIL break_no_valid: got %0d valid clks expected 0", valid_cycles - v0);
    end
    send_frame(8'h55, 1'b1);
    line(1'b1, 2 * Bit);
    n_checks++;
    if (got.size() != g0 + 1 || got[got.size()-1] !== 8'h55) begin
      n_fail++;
      $display("FAIL break_recover: got %0d bytes expected 1 byte 55", got.size() - g0);
    end
    n_checks++;
    if (fe_cnt - f0 != 1) begin
      n_fail++;
      $display("FAIL break_recover_fe: got %0d pulses expected 1", fe_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int g0 = got.size(), o0 = ov_cnt, f0 = fe_cnt;
    rx_ready = 1'b0;
    send_frame(8'h01, 1'b1);
    send_frame(8'h02, 1'b1);
    line(1'b1, Bit);
    n_checks++;
    if (ov_cnt - o0 != 1 || fe_cnt != f0) begin
      n_fail++;
      $display("FAIL b2b_overrun: ov=%0d fe=%0d expected 1 0", ov_cnt - o0, fe_cnt - f0);
    end
    n_checks++;
    if (rx_valid !== 1'b1 || rx_data !== 8'h01) begin
      n_fail++;
      $display("FAIL b2b_held: valid=%b data=%h expected 1 01", rx_valid, rx_data);
    end
    rx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drop: valid=%b expected 0", rx_valid);
    end
    @(posedge clk);
    #2;
    n_checks++;
    if (got.size() != g0 + 1 || got[got.size()-1] !== 8'h01) begin
      n_fail++;
      $display("FAIL b2b_accept: got %0d bytes expected 1 byte 01", got.size() - g0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] buf_b = '0;
    logic       buf_full = 1'b0;
    int g0 = got.size(), f0 = fe_cnt, o0 = ov_cnt, exp_fe = 0, exp_ov = 0;
    for (int n = 0; n < 14; n++) begin
      logic [7:0] b = 8'($urandom);
      logic       rdy = ($urandom_range(0, 3) != 0);
      logic       bad = ($urandom_range(0, 4) == 0);
      rx_ready = rdy;
      // A ready consumer empties the one-deep buffer during the idle gap.
      if (rdy && buf_full) begin
        exp_q.push_back(buf_b);
        buf_full = 1'b0;
      end
      line(1'b1, 2 * Bit + int'($urandom_range(0, 20)));
      send_frame(b, !bad);
      if (bad) begin
        exp_fe++;
        line(1'b0, Bit * int'($urandom_range(1, 6)));
        line(1'b1, Bit);
      end else if (buf_full) begin
        exp_ov++;
      end else if (rdy) begin
        exp_q.push_back(b);
      end else begin
        buf_b    = b;
        buf_full = 1'b1;
      end
    end
    rx_ready = 1'b1;
    if (buf_full) exp_q.push_back(buf_b);
    line(1'b1, 3 * Bit);
    n_checks++;
    if (got.size() - g0 != exp_q.size()) begin
      n_fail++;
      $display("FAIL rand_count: got %0d bytes expected %0d", got.size() - g0, exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_checks++;
        if (got[g0 + i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rand_byte[%0d]: got %h expected %h", i, got[g0 + i], exp_q[i]);
        end
      end
    end
    n_checks++;
    if (fe_cnt - f0 != exp_fe || ov_cnt - o0 != exp_ov) begin
      n_fail++;
      $display("FAIL rand_flags: fe=%0d ov=%0d expected %0d %0d", fe_cnt - f0, ov_cnt - o0,
               exp_fe, exp_ov);
    end
    n_checks++;
    if (both_cnt != 0 || stab_err != 0) begin
      n_fail++;
      $display("FAIL rand_invariants: same_clk=%0d unstable=%0d expected 0 0", both_cnt, stab_err);
    end
  endtask

  task automatic test_midframe_reset();
    int g0, f0;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    line(1'b1, Bit);
    line(1'b0, Bit);
    line(1'b1, 4 * Bit);
    n_checks++;
    if (rx_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mrst_pre: valid=%b busy=%b expected 1 1", rx_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({rx_valid, frame_err, overrun, busy, rx_data} !== 12'h000) begin
      n_fail++;
      $display("FAIL mrst_outputs: got %h expected 000",
               {rx_valid, frame_err, overrun, busy, rx_data});
    end
    rxd = 1'b1;
    @(posedge clk);
    #2;
    rst_n    = 1'b1;
    rx_ready = 1'b1;
    line(1'b1, Bit);
    g0 = got.size();
    f0 = fe_cnt;
    send_frame(8'hFF, 1'b1);
    line(1'b1, 2 * Bit);
    n_checks++;
    if (got.size() != g0 + 1 || got[got.size()-1] !== 8'hFF || fe_cnt != f0) begin
      n_fail++;
      $display("FAIL mrst_recover: bytes=%0d fe=%0d expected 1 byte ff, fe 0",
               got.size() - g0, fe_cnt - f0);
    end
  endtask

  task automatic test_glitch_bit();
    int g0 = got.size();
    rx_ready = 1'b1;
    line(1'b0, 3 * Bit);
    line(1'b0, 8);
    line(1'b1, 1);
    line(1'b0, 7);
    line(1'b0, 5 * Bit);
    line(1'b1, 3 * Bit);
    n_checks++;
    if (got.size() != g0 + 1 || got[got.size()-1] !== 8'h00) begin
      n_fail++;
      $display("FAIL glitch_vote: bytes=%0d last=%h expected 1 byte 00", got.size() - g0,
               (got.size() > 0) ? got[got.size()-1] : 8'hxx);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch_start();
    test_break();
    test_back_to_back();
    test_random();
    test_midframe_reset();
    test_glitch_bit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
